// File: rtl/serial_pattern_detector.sv
// rtl/serial_pattern_detector.sv - serial bit-stream pattern detector with saturating match counter
// Samples one bit per enabled edge and pulses a registered flag when the last WIDTH bits equal PATTERN.
module serial_pattern_detector #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] PATTERN   = 4'b1011,
  parameter bit               OVERLAP   = 1'b1,
  parameter int unsigned      CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in,
  input  logic                 clear,
  output logic                 out,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [WIDTH-1:0]     history
);

  localparam int unsigned FW = $clog2(WIDTH + 1);

  typedef enum logic {FILLING = 1'b0, ARMED = 1'b1} state_t;

  state_t               state, state_n;
  logic [FW-1:0]        fill, fill_n;
  logic [WIDTH-1:0]     history_n;
  logic [WIDTH-1:0]     shifted;
  logic [CNT_WIDTH-1:0] count_n;
  logic                 out_n;
  logic                 hit;

  assign shifted = {history[WIDTH-2:0], in};
  // The sample that completes the fill is the first one allowed to match.
  assign hit = en && !clear && (state == ARMED || fill == FW'(WIDTH - 1)) && (shifted == PATTERN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILLING;
      fill        <= '0;
      history     <= '0;
      match_count <= '0;
      out         <= 1'b0;
    end else begin
      state       <= state_n;
      fill        <= fill_n;
      history     <= history_n;
      match_count <= count_n;
      out         <= out_n;
    end
  end

  always_comb begin
    state_n   = state;
    fill_n    = fill;
    history_n = history;
    if (clear) begin
      state_n   = FILLING;
      fill_n    = '0;
      history_n = '0;
    end else if (en) begin
      history_n = shifted;
      if (state == FILLING) begin
        fill_n = fill + FW'(1);
        if (fill_n == FW'(WIDTH)) state_n = ARMED;
      end
      // Non-overlapping mode discards the matched bits and starts a fresh fill.
      if (hit && !OVERLAP) begin
        state_n   = FILLING;
        fill_n    = '0;
        history_n = '0;
      end
    end
  end

  always_comb begin
    out_n   = 1'b0;
    count_n = match_count;
    if (clear) begin
      count_n = '0;
    end else if (hit) begin
      out_n = 1'b1;
      if (match_count != {CNT_WIDTH{1'b1}}) count_n = match_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb/tb_serial_pattern_detector.sv - randomized and directed checks of serial_pattern_detector
// Three instances share stimulus: default, non-overlapping, and a 1111 pattern with a 2-bit counter.
module tb_serial_pattern_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic din = 1'b0;
  logic clear = 1'b0;

  logic       out0, out1, out2;
  logic [7:0] mc0, mc1;
  logic [1:0] mc2;
  logic [3:0] h0, h1, h2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_pattern_detector dut0 (
    .clk(clk), .reset(reset), .en(en), .in(din), .clear(clear),
    .out(out0), .match_count(mc0), .history(h0));

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .en(en), .in(din), .clear(clear),
    .out(out1), .match_count(mc1), .history(h1));

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .in(din), .clear(clear),
    .out(out2), .match_count(mc2), .history(h2));

  // Reference model: the valid bits since the last reset/clear/flush, newest at the back.
  bit         mq[3][$];
  int         mcnt[3];
  bit         mout[3];
  logic [3:0] mpat[3] = '{4'b1011, 4'b1011, 4'b1111};
  bit         mov[3]  = '{1'b1, 1'b0, 1'b1};
  int         mmax[3] = '{255, 255, 3};

  function automatic logic [3:0] model_hist(int k);
    logic [3:0] h = 4'b0;
    for (int j = 0; j < mq[k].size(); j++) h = {h[2:0], mq[k][j]};
    return h;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mcnt[k] = 0;
      mout[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit e, input bit b, input bit c);
    for (int k = 0; k < 3; k++) begin
      mout[k] = 1'b0;
      if (c) begin
        mq[k].delete();
        mcnt[k] = 0;
      end else if (e) begin
        mq[k].push_back(b);
        if (mq[k].size() > 4) void'(mq[k].pop_front());
        if (mq[k].size() == 4 && model_hist(k) == mpat[k]) begin
          mout[k] = 1'b1;
          if (mcnt[k] < mmax[k]) mcnt[k]++;
          if (!mov[k]) mq[k].delete();
        end
      end
    end
  endtask

  task automatic step(input bit e, input bit b, input bit c);
    en = e;
    din = b;
    clear = c;
    @(posedge clk);
    model_step(e, b, c);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
    clear = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0]  o;
    logic [11:0] h;
    logic [17:0] c;
    #2;
    o = {out0, out1, out2};
    h = {h0, h1, h2};
    c = {mc0, mc1, mc2};
    checks++; if (o !== 3'b000) begin errors++; $display("FAIL reset_out got=%b exp=000", o); end
    checks++; if (h !== 12'h000) begin errors++; $display("FAIL reset_history got=%h exp=000", h); end
    checks++; if (c !== 18'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", c); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] seq = 4'b1011;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, seq[3-i], 1'b0);
      checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL basic_early_out idx=%0d got=%b exp=0", i, out0); end
    end
    step(1'b1, seq[0], 1'b0);
    checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL basic_out got=%b exp=1", out0); end
    checks++; if (mc0 !== 8'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", mc0); end
    checks++; if (h0 !== 4'b1011) begin errors++; $display("FAIL basic_history got=%b exp=1011", h0); end
    checks++; if (out2 !== 1'b0) begin errors++; $display("FAIL basic_other_pattern got=%b exp=0", out2); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b exp=0", out0); end
  endtask

  task automatic test_overlap();
    logic [6:0] seq = 7'b1011011;
    logic [6:0] p0 = '0;
    logic [6:0] p1 = '0;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, seq[6-i], 1'b0);
      p0[i] = out0;
      p1[i] = out1;
    end
    checks++; if (p0 !== 7'b1001000) begin errors++; $display("FAIL overlap_pulses got=%b exp=1001000", p0); end
    checks++; if (mc0 !== 8'd2) begin errors++; $display("FAIL overlap_count got=%0d exp=2", mc0); end
    checks++; if (p1 !== 7'b0001000) begin errors++; $display("FAIL nooverlap_pulses got=%b exp=0001000", p1); end
    checks++; if (mc1 !== 8'd1) begin errors++; $display("FAIL nooverlap_count got=%0d exp=1", mc1); end
  endtask

  task automatic test_enable_gating();
    apply_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0] ? 1'b0 : 1'b1, 1'b0);
      checks++; if (h0 !== 4'b0010) begin errors++; $display("FAIL gate_history idx=%0d got=%b exp=0010", i, h0); end
      checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL gate_out idx=%0d got=%b exp=0", i, out0); end
    end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL gate_early_out got=%b exp=0", out0); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL gate_match got=%b exp=1", out0); end
    checks++; if (mc0 !== 8'd1) begin errors++; $display("FAIL gate_count got=%0d exp=1", mc0); end
  endtask

  task automatic test_saturation();
    int exp_c[8] = '{0, 0, 0, 1, 2, 3, 3, 3};
    int pulses = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (out2) pulses++;
      checks++; if (out2 !== (i >= 3)) begin errors++; $display("FAIL sat_out idx=%0d got=%b exp=%b", i, out2, (i >= 3)); end
      checks++; if (mc2 !== 2'(exp_c[i])) begin errors++; $display("FAIL sat_count idx=%0d got=%0d exp=%0d", i, mc2, exp_c[i]); end
    end
    checks++; if (pulses != 5) begin errors++; $display("FAIL sat_pulses got=%0d exp=5", pulses); end
  endtask

  task automatic test_clear();
    logic [3:0] seq = 4'b1011;
    apply_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL clear_out got=%b exp=0", out0); end
    checks++; if (h0 !== 4'b0000) begin errors++; $display("FAIL clear_history got=%b exp=0000", h0); end
    checks++; if (mc0 !== 8'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", mc0); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[3-i], 1'b0);
      checks++; if (out0 !== (i == 3)) begin errors++; $display("FAIL clear_post_out idx=%0d got=%b exp=%b", i, out0, (i == 3)); end
    end
    checks++; if (mc0 !== 8'd1) begin errors++; $display("FAIL clear_post_count got=%0d exp=1", mc0); end
  endtask

  task automatic test_async_reset();
    logic [6:0] seq = 7'b1011011;
    apply_reset();
    for (int i = 0; i < 7; i++) step(1'b1, seq[6-i], 1'b0);
    checks++; if (mc0 !== 8'd2) begin errors++; $display("FAIL areset_pre_count got=%0d exp=2", mc0); end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL areset_out got=%b exp=0", out0); end
    checks++; if (mc0 !== 8'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", mc0); end
    checks++; if (h0 !== 4'b0000) begin errors++; $display("FAIL areset_history got=%b exp=0000", h0); end
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++; if (out0 !== 1'b0) begin errors++; $display("FAIL areset_filling_out got=%b exp=0", out0); end
    checks++; if (h0 !== 4'b0101) begin errors++; $display("FAIL areset_history_after got=%b exp=0101", h0); end
    step(1'b1, 1'b1, 1'b0);
    checks++; if (out0 !== 1'b1) begin errors++; $display("FAIL areset_refill_match got=%b exp=1", out0); end
  endtask

  task automatic test_random();
    logic       o[3];
    logic [7:0] c[3];
    logic [3:0] h[3];
    bit e, b, cl;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      e  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 40) == 0);
      step(e, b, cl);
      o = '{out0, out1, out2};
      c = '{mc0, mc1, {6'b0, mc2}};
      h = '{h0, h1, h2};
      for (int k = 0; k < 3; k++) begin
        checks++; if (o[k] !== mout[k]) begin errors++; $display("FAIL rand_out dut=%0d cyc=%0d got=%b exp=%b", k, n, o[k], mout[k]); end
        checks++; if (c[k] !== 8'(mcnt[k])) begin errors++; $display("FAIL rand_count dut=%0d cyc=%0d got=%0d exp=%0d", k, n, c[k], mcnt[k]); end
        checks++; if (h[k] !== model_hist(k)) begin errors++; $display("FAIL rand_history dut=%0d cyc=%0d got=%b exp=%b", k, n, h[k], model_hist(k)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_enable_gating();
    test_saturation();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Parametrised serial bit-stream pattern detector: the sequential successor to the single-bit in/out lab block. It samples a 1-bit serial input under an enable, compares the last WIDTH valid bits against a compile-time PATTERN, and pulses a registered match flag. It also keeps a saturating match counter. It sits directly behind a serial source (switch, UART RX bit, test stimulus) and feeds LEDs or a downstream control FSM.

## Interface
- WIDTH, 4: pattern length in bits, 2..32.
- PATTERN, 4'b1011: pattern to detect; MSB is the oldest bit, LSB the newest.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = history is flushed after each match.
- CNT_WIDTH, 8: width of match counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  sample strobe; `in` is consumed only on edges where en=1.
- in  input  1  serial data bit.
- clear  input  1  synchronous clear of history, fill state and counter.
- out  output  1  match pulse, high for exactly one cycle per match.
- match_count  output  CNT_WIDTH  number of matches since reset/clear, saturating.
- history  output  WIDTH  current shift register contents, newest bit in LSB.

## Operation
- Shift register `history`: on en=1, history <= {history[WIDTH-2:0], in}.
- Fill counter `fill` (0..WIDTH) tracks valid bits. FSM with two states:
  - FILLING (fill<WIDTH): each en increments fill. The transition to ARMED occurs when fill reaches WIDTH. No match can occur while FILLING, even if history==PATTERN, e.g. for an all-zero pattern after reset.
  - ARMED: each en sample compares the new history value {history[WIDTH-2:0], in} with PATTERN.
- Match, OVERLAP=1: out <= 1, match_count increments, state stays ARMED.
- Match, OVERLAP=0: out <= 1, match_count increments, history <= 0, fill <= 0, state goes to FILLING. The matching bits are not reused.
- match_count saturates at 2^CNT_WIDTH-1; further matches still pulse out.
- en=0: history, fill, state and match_count hold; out <= 0.
- clear=1: history, fill, match_count and out are set to 0 and the state goes to FILLING. clear has priority over en; a bit presented with clear is discarded.
- reset=1 (any time, asynchronous): same state as clear. out=0, match_count=0, history=0, FILLING. reset has priority over everything.

## Timing
- Latency: the sample completing a match is taken at edge k. out is high from edge k to edge k+1, and match_count shows the increment after edge k.
- out is fully registered; there is no combinational path from in/en to out.
- Back-to-back matches are possible only with OVERLAP=1 and a self-overlapping PATTERN. With consecutive en and PATTERN=4'b1111, out stays high on consecutive cycles.
- OVERLAP=0: at least WIDTH en samples separate two matches.
- Reset deassertion: the first sample is taken on the first rising edge with reset low and en high.
- Mid-pattern reset or clear: partial history is lost, and the next match needs WIDTH fresh samples.

## Test plan
- Basic match (defaults): reset, then in=1,0,1,1 with en=1 on 4 edges. Required: out=1 for one cycle after the 4th edge, match_count=1, history=4'b1011.
- Overlap mode: stream 1,0,1,1,0,1,1. OVERLAP=1 requires pulses after the 4th and 7th samples with match_count=2. OVERLAP=0 requires one pulse after the 4th sample only, with match_count=1.
- Enable gating: send 1,0 with en=1, then 3 cycles of en=0 with in toggling, then 1,1 with en=1. Required: one match after the last sample; history does not change during en=0; out stays 0 during the gap.
- Counter saturation: CNT_WIDTH=2, OVERLAP=1, PATTERN=4'b1111, 8 consecutive 1 samples. Required: 5 out pulses, with match_count 1,2,3,3,3.
- Clear priority: send 1,0,1, then clear=1 with en=1 and in=1. Then 1,0,1,1. Required: no pulse at the clear edge, history=0 after clear, one match after the 4th post-clear sample, match_count=1.
- Async reset mid-operation: after two matches, assert reset between clock edges. Required: immediately out=0, match_count=0, history=0. After release, 1,0,1 gives no match because FILLING needs 4 samples.
